soc_timer_event_arbiter: RTL and testbench
==========================================

Name: soc_timer_event_arbiter

Overview:
- Sits between the per-timer expiry pulses of the SoC timer block and the CPU interrupt path.
- Latches each timer's expiry into a pending bit and arbitrates round-robin among pending timers.
- Queues granted timer IDs in a small FIFO, so software can dequeue exactly which timer fired without scanning a status register.
- Reports events lost to coalescing via a sticky overflow flag.

Parameters:
- TIMER_COUNT, 16, number of timer event inputs; legal range 1..16.
- FIFO_DEPTH, 4, event ID queue depth; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- res  in  1  asynchronous, active-low reset.
- event_pulse  in  TIMER_COUNT  one-cycle expiry pulse per timer.
- event_mask  in  TIMER_COUNT  1 = timer may raise events; 0 = its pulses are ignored.
- evt_valid  out  1  FIFO head holds a valid timer ID.
- evt_id  out  4  timer ID at FIFO head; 0 when evt_valid=0.
- evt_ready  in  1  consumer accepts head; pop happens on the edge where evt_valid&evt_ready.
- pending  out  TIMER_COUNT  latched, not-yet-queued events.
- irq  out  1  registered; equals evt_valid.
- overflow  out  1  sticky: at least one event was lost.
- overflow_clear  in  1  synchronous clear of overflow.

Behaviour:
- Reset (res=0, asynchronous):
  - pending=0, FIFO empty, evt_valid=0, evt_id=0, irq=0, overflow=0.
  - rr_last=TIMER_COUNT-1, so timer 0 has first priority.
- Pending set: on each posedge, pending[i] is set if event_pulse[i]&event_mask[i].
  - Clearing a mask bit does not clear an already-set pending bit.
- Grant: each cycle, if pending≠0 and can_push, grant the first set bit searching upward from rr_last+1 with wrap.
  - The granted ID is pushed into the FIFO, pending[g] is cleared, and rr_last=g.
  - At most one grant per cycle.
- can_push = !full || (evt_valid && evt_ready). Push and pop on the same edge are legal at full; count is then unchanged.
- Simultaneous set and clear on the same bit (new pulse on the timer being granted): set wins, so pending stays 1.
- Coalescing loss: a masked-in pulse on a bit that is pending and not granted this cycle sets overflow=1. Pending stays 1, and only one event is ultimately queued.
- Overflow priority: setting overflow takes priority over overflow_clear in the same cycle.
- Latency: pulse sampled at edge k → pending at k → grant and push at edge k+1 → evt_valid=1 after edge k+1 when the FIFO was empty. Minimum is 2 edges from pulse to valid.
- FIFO ordering: strict FIFO. evt_id is driven from the storage entry at the read pointer; no combinational path from event_pulse to evt_valid.
- Empty: no pop occurs regardless of evt_ready.
- Full without pop: no grant; pending bits hold and keep accumulating.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits with wrap, plus a count of log2(FIFO_DEPTH)+1 bits.
- TIMER_COUNT<16: IDs ≥ TIMER_COUNT are never produced; unused search positions are skipped.
- No explicit FSM. State consists of pending, rr_last, the FIFO pointers/count, and overflow.

Decomposition:
- Package soc_timer_pkg:
  - TIMER_MAX=16.
  - typedef timer_id_t (logic [3:0]).
  - function rr_pick(req, last) returning {found, id}.
- Sub-module soc_event_fifo (parameters WIDTH, DEPTH):
  - ports push/din/full, pop/dout/empty/count.
  - Same asynchronous active-low reset.
  - Reusable for other peripheral event queues.

Test Plan:
- Single event: pulse timer 3, ready=1 → pending[3]=1 after 1 edge; evt_valid=1, evt_id=3 after 2 edges; popped next edge; irq returns to 0.
- Simultaneous events: pulse timers 0, 5, 9 in one cycle, ready=1 → evt_id sequence 0,5,9 on consecutive cycles; overflow stays 0.
- Round-robin fairness: timers 1 and 2 pulse every cycle, ready=1 → queued order alternates 1,2,1,2…; no starvation; overflow set because of coalescing.
- Full FIFO: ready=0, pulse timers 0..5 once → FIFO holds 0,1,2,3 and pending=0x30. Raise ready → 4,5 follow in order; overflow=0.
- Overflow and mask: ready=0, FIFO full, pulse timer 7 twice → overflow=1, pending[7]=1, one ID 7 eventually queued. Pulse timer 8 with mask[8]=0 → no effect. overflow_clear → overflow=0.
- Reset mid-operation: FIFO holding 2 IDs, pending=0x3, assert res asynchronously → all outputs 0 immediately. After release, the first grant goes to timer 0.

Source files
------------

// File: rtl/soc_timer_event_arbiter_pkg.sv
// Shared types and the round-robin search used by the timer event arbiter.
package soc_timer_pkg;

  localparam int TIMER_MAX = 16;

  typedef logic [3:0] timer_id_t;

  // Find the first set request after 'last', wrapping through all 16 positions.
  // The result is {found, id}. Positions that are not wired to a timer must be
  // driven 0 by the caller so that the search skips them.
  function automatic logic [4:0] rr_pick(input logic [TIMER_MAX-1:0] req,
                                         input timer_id_t last);
    logic      found;
    timer_id_t id;
    timer_id_t idx;
    found = 1'b0;
    id    = '0;
    for (int off = 1; off <= TIMER_MAX; off++) begin
      idx = last + timer_id_t'(off);
      if (!found && req[idx]) begin
        found = 1'b1;
        id    = idx;
      end
    end
    return {found, id};
  endfunction

endpackage

// File: rtl/soc_timer_event_arbiter_if.sv
// Consumer-side event handshake: the head of the event queue and its ready.
interface soc_timer_event_arbiter_if;
  import soc_timer_pkg::*;

  logic      evt_valid;
  timer_id_t evt_id;
  logic      evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);

endinterface

// File: rtl/soc_timer_event_arbiter_fifo.sv
// Small synchronous FIFO for peripheral event IDs. A push is accepted when not
// full, or when full with a pop on the same edge; a pop is ignored when empty.
module soc_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage write and pointer/count bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/soc_timer_event_arbiter.sv
// Latches timer expiry pulses into pending bits, grants one pending timer per
// cycle round-robin into an ID queue, and flags events lost to coalescing.
module soc_timer_event_arbiter
  import soc_timer_pkg::*;
#(
  parameter int TIMER_COUNT = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic [TIMER_COUNT-1:0] event_pulse,
  input  logic [TIMER_COUNT-1:0] event_mask,
  output logic [TIMER_COUNT-1:0] pending,
  output logic                   irq,
  output logic                   overflow,
  input  logic                   overflow_clear,
  soc_timer_event_arbiter_if.master evt_if
);

  localparam timer_id_t RR_RESET = timer_id_t'(TIMER_COUNT - 1);
  localparam int        CW       = $clog2(FIFO_DEPTH) + 1;

  logic [TIMER_COUNT-1:0] r_pending;
  timer_id_t              r_rr_last;
  logic                   r_overflow;

  logic [TIMER_MAX-1:0]   w_req;
  logic [4:0]             w_pick;
  timer_id_t              w_pick_id;
  logic                   w_pick_found;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_count;
  timer_id_t              w_dout;
  logic                   w_pop;
  logic                   w_can_push;
  logic                   w_grant;
  logic [TIMER_COUNT-1:0] w_set;
  logic [TIMER_COUNT-1:0] w_gnt_oh;
  logic                   w_lost;

  // Widen pending to the full search space; unused positions stay 0 so they are skipped.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < TIMER_COUNT; i++) w_req[i] = r_pending[i];
  end

  assign w_pick       = rr_pick(w_req, r_rr_last);
  assign w_pick_found = w_pick[4];
  assign w_pick_id    = w_pick[3:0];

  assign w_pop      = !w_empty && evt_if.evt_ready;
  assign w_can_push = !w_full || w_pop;
  assign w_grant    = w_pick_found && w_can_push;
  assign w_set      = event_pulse & event_mask;

  // One-hot of this cycle's grant, and detection of pulses merged into a waiting bit.
  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < TIMER_COUNT; i++)
      w_gnt_oh[i] = w_grant && (w_pick_id == timer_id_t'(i));
    w_lost = |(w_set & r_pending & ~w_gnt_oh);
  end

  // Pending, round-robin pointer and sticky overflow; a new pulse wins over a grant clear.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_pending  <= '0;
      r_rr_last  <= RR_RESET;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_gnt_oh) | w_set;
      if (w_grant) r_rr_last <= w_pick_id;
      if (w_lost)              r_overflow <= 1'b1;
      else if (overflow_clear) r_overflow <= 1'b0;
    end
  end

  soc_event_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (w_grant),
    .din   (w_pick_id),
    .full  (w_full),
    .pop   (w_pop),
    .dout  (w_dout),
    .empty (w_empty),
    .count (w_count)
  );

  // All outputs decode flops only, so nothing combinational reaches them from the pulses.
  assign evt_if.evt_valid = !w_empty;
  assign evt_if.evt_id    = w_empty ? '0 : w_dout;
  assign irq              = (w_count != '0);
  assign pending          = r_pending;
  assign overflow         = r_overflow;

endmodule

// File: tb/tb_soc_timer_event_arbiter.sv
// Directed bench for the timer event arbiter with hand-computed expectations.
module tb_soc_timer_event_arbiter;

  logic        clk;
  logic        res;
  logic [15:0] event_pulse;
  logic [15:0] event_mask;
  logic [15:0] pending;
  logic        irq;
  logic        overflow;
  logic        overflow_clear;

  int n_tests;
  int n_fail;

  soc_timer_event_arbiter_if evt_if ();

  soc_timer_event_arbiter #(
    .TIMER_COUNT (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk            (clk),
    .res            (res),
    .event_pulse    (event_pulse),
    .event_mask     (event_mask),
    .pending        (pending),
    .irq            (irq),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .evt_if         (evt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b0;
    step();
    step();
    res = 1'b1;
  endtask

  initial begin
    int exp_id [5];
    n_tests        = 0;
    n_fail         = 0;
    res            = 1'b0;
    event_pulse    = '0;
    event_mask     = 16'hFFFF;
    overflow_clear = 1'b0;
    evt_if.evt_ready = 1'b1;

    // Reset state
    step();
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_id", evt_if.evt_id, 0);
    chk("rst_pending", pending, 0);
    chk("rst_irq", irq, 0);
    chk("rst_overflow", overflow, 0);
    res = 1'b1;
    step();

    // Simultaneous events 0,5,9: served in order starting from timer 0
    event_pulse = 16'h0221;
    step();
    event_pulse = '0;
    chk("sim_pending", pending, 16'h0221);
    chk("sim_valid0", evt_if.evt_valid, 0);
    step();
    chk("sim_id0", evt_if.evt_id, 0);
    chk("sim_valid1", evt_if.evt_valid, 1);
    step();
    chk("sim_id5", evt_if.evt_id, 5);
    step();
    chk("sim_id9", evt_if.evt_id, 9);
    step();
    chk("sim_empty", evt_if.evt_valid, 0);
    chk("sim_overflow", overflow, 0);

    // Single event on timer 3: pending after one edge, valid after two, popped after three
    event_pulse = 16'h0008;
    step();
    event_pulse = '0;
    chk("one_pending", pending, 16'h0008);
    chk("one_valid_early", evt_if.evt_valid, 0);
    step();
    chk("one_valid", evt_if.evt_valid, 1);
    chk("one_id", evt_if.evt_id, 3);
    chk("one_irq", irq, 1);
    chk("one_pending_clr", pending, 0);
    step();
    chk("one_popped", evt_if.evt_valid, 0);
    chk("one_irq_low", irq, 0);

    // Round robin: timers 1 and 2 pulse every cycle; grants alternate starting at 1
    exp_id = '{1, 2, 1, 2, 1};
    event_pulse = 16'h0006;
    step();
    chk("rr_pending", pending, 16'h0006);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rr_id%0d", i), evt_if.evt_id, exp_id[i]);
    end
    event_pulse = '0;
    step();
    chk("rr_tail_id2", evt_if.evt_id, 2);
    step();
    chk("rr_tail_id1", evt_if.evt_id, 1);
    step();
    chk("rr_drained", evt_if.evt_valid, 0);
    chk("rr_pending_clr", pending, 0);
    chk("rr_overflow", overflow, 1);
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    chk("rr_ovf_cleared", overflow, 0);

    // Full FIFO: six timers at once with the consumer stalled
    do_reset();
    evt_if.evt_ready = 1'b0;
    event_pulse = 16'h003F;
    step();
    event_pulse = '0;
    for (int i = 0; i < 4; i++) step();
    step();
    chk("full_head", evt_if.evt_id, 0);
    chk("full_pending", pending, 16'h0030);
    evt_if.evt_ready = 1'b1;
    step();
    chk("full_id1", evt_if.evt_id, 1);
    chk("full_pending_a", pending, 16'h0020);
    step();
    chk("full_id2", evt_if.evt_id, 2);
    chk("full_pending_b", pending, 0);
    step();
    chk("full_id3", evt_if.evt_id, 3);
    step();
    chk("full_id4", evt_if.evt_id, 4);
    step();
    chk("full_id5", evt_if.evt_id, 5);
    step();
    chk("full_empty", evt_if.evt_valid, 0);
    chk("full_overflow", overflow, 0);

    // Overflow and mask: fill the queue with 0..3, then hit timer 7 twice
    evt_if.evt_ready = 1'b0;
    event_pulse = 16'h000F;
    step();
    event_pulse = '0;
    for (int i = 0; i < 4; i++) step();
    chk("ovf_pending0", pending, 0);
    event_pulse = 16'h0080;
    step();
    chk("ovf_first", overflow, 0);
    chk("ovf_pend7", pending, 16'h0080);
    step();
    event_pulse = '0;
    chk("ovf_second", overflow, 1);
    event_mask  = 16'hFEFF;
    event_pulse = 16'h0100;
    step();
    event_pulse = '0;
    event_mask  = 16'hFFFF;
    chk("ovf_masked", pending, 16'h0080);
    overflow_clear = 1'b1;
    event_pulse    = 16'h0080;
    step();
    event_pulse = '0;
    chk("ovf_set_wins", overflow, 1);
    step();
    overflow_clear = 1'b0;
    chk("ovf_cleared", overflow, 0);
    evt_if.evt_ready = 1'b1;
    step();
    chk("ovf_id1", evt_if.evt_id, 1);
    chk("ovf_pending_clr", pending, 0);
    step();
    chk("ovf_id2", evt_if.evt_id, 2);
    step();
    chk("ovf_id3", evt_if.evt_id, 3);
    step();
    chk("ovf_id7", evt_if.evt_id, 7);
    step();
    chk("ovf_empty", evt_if.evt_valid, 0);

    // Reset mid-operation: two IDs queued and timers 0,1 pending
    evt_if.evt_ready = 1'b0;
    event_pulse = 16'h0030;
    step();
    event_pulse = '0;
    step();
    event_pulse = 16'h0003;
    step();
    event_pulse = '0;
    chk("mid_valid", evt_if.evt_valid, 1);
    chk("mid_id", evt_if.evt_id, 4);
    chk("mid_pending", pending, 16'h0003);
    #2;
    res = 1'b0;
    #1;
    chk("mid_rst_valid", evt_if.evt_valid, 0);
    chk("mid_rst_id", evt_if.evt_id, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_overflow", overflow, 0);
    step();
    res = 1'b1;
    evt_if.evt_ready = 1'b1;
    event_pulse = 16'h0003;
    step();
    event_pulse = '0;
    step();
    chk("post_rst_id0", evt_if.evt_id, 0);
    step();
    chk("post_rst_id1", evt_if.evt_id, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
